// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-8 frame sequencer.
//   CRC_W     : CRC register width
//   CRC_POLY  : default polynomial (x^8+x^2+x+1, MSB-first)
//   CRC_INIT  : default CRC register value loaded at frame start
//   state_t   : frame sequencer states
package crc_pkg;

  localparam int unsigned CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    EMIT = 3'd2,
    CHKB = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/crc8_step.sv
// Combinational CRC-8 byte step: crc_next = crc advanced by one data byte,
// MSB-first, no reflection.
//   crc      : current CRC register
//   data     : byte to absorb
//   crc_next : CRC after absorbing data
module crc8_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] stage;

  // Eight unrolled shift/XOR stages, one per data bit.
  always_comb begin
    stage = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      stage = stage[CRC_W-1] ? ((stage << 1) ^ POLY) : (stage << 1);
    end
    crc_next = stage;
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the byte-wide CRC-8 datapath.
// Generate mode forwards a length-prefixed payload and appends its CRC byte;
// check mode consumes payload plus received CRC and reports crc_ok.
//   clk, rst_n            : clock, async active-low reset
//   start, mode, len      : frame start strobe, 0=gen/1=check, payload length
//   abort                 : synchronous frame abort
//   in_valid/ready/data   : input byte stream
//   out_valid/ready/data  : output byte stream, out_last marks the CRC byte
//   busy, done            : activity flag, one-cycle completion pulse
//   crc_ok, crc_value     : check result, running/final CRC register
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter int unsigned      LEN_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_POLY,
  parameter logic [CRC_W-1:0] INIT  = CRC_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [CRC_W-1:0] crc_value
);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             ok_q, ok_d;
  logic             busy_q, done_q;
  logic [CRC_W-1:0] crc_step;
  logic             abort_act;

  crc8_step #(.POLY(POLY)) u_step (
    .crc      (crc_q),
    .data     (in_data),
    .crc_next (crc_step)
  );

  assign abort_act = abort && (state_q != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      crc_q   <= INIT;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    ok_d      = ok_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;

    if (abort_act) begin
      // Handshakes stay low so no byte moves in the abort cycle.
      state_d = IDLE;
      ok_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_d = mode;
            cnt_d  = len;
            crc_d  = INIT;
            if (len != '0)  state_d = DATA;
            else if (mode)  state_d = CHKB;
            else            state_d = EMIT;
          end
        end
        DATA: begin
          if (!mode_q) begin
            // Pass-through: the link's ready paces the upstream source.
            out_valid = in_valid;
            in_ready  = out_ready;
            out_data  = in_data;
          end else begin
            in_ready = 1'b1;
          end
          if (in_valid && in_ready) begin
            crc_d = crc_step;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = mode_q ? CHKB : EMIT;
          end
        end
        EMIT: begin
          out_valid = 1'b1;
          out_data  = crc_q;
          out_last  = 1'b1;
          if (out_ready) state_d = DONE;
        end
        CHKB: begin
          in_ready = 1'b1;
          if (in_valid) begin
            crc_d   = crc_step;
            ok_d    = (crc_step == '0);
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign crc_ok    = ok_q;
  assign crc_value = crc_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
module tb_crc_frame_ctrl;

  localparam int unsigned LEN_W = 8;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, mode, abort;
  logic [LEN_W-1:0] len;
  logic             in_valid, in_ready;
  logic [7:0]       in_data;
  logic             out_valid, out_ready;
  logic [7:0]       out_data;
  logic             out_last, busy, done, crc_ok;
  logic [7:0]       crc_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_value (crc_value)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bit-serial polynomial division of the whole message (x^8+x^2+x+1, init 0).
  function automatic logic [7:0] ref_crc(input byte_q_t msg);
    logic [7:0] r = 8'h00;
    logic       fb;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_done"},      done,      0);
    check_eq({tag, "_crc_ok"},    crc_ok,    0);
    check_eq({tag, "_crc_value"}, crc_value, 0);
    check_eq({tag, "_in_ready"},  in_ready,  0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_last"},  out_last,  0);
    check_eq({tag, "_out_data"},  out_data,  0);
  endtask

  task automatic start_frame(input bit m, input int n);
    @(negedge clk);
    start = 1'b1; mode = m; len = LEN_W'(n);
    in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    @(posedge clk);
  endtask

  // Generate frame with random stalls on both sides; optional start pokes while busy.
  task automatic run_gen(input byte_q_t pl, input int stall_pct, input bit poke, input string tag);
    byte_q_t    got;
    bit         lasts[$];
    int         idx = 0, last_x = -10;
    bit         held = 0, prev_stall = 0, done_seen = 0;
    logic [7:0] prev_data = 8'h00;
    int         n = pl.size();
    byte_q_t    exp;
    logic [7:0] exp_crc = ref_crc(pl);
    exp = pl;
    exp.push_back(exp_crc);
    start_frame(1'b0, n);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      mode  = 1'($urandom);
      len   = LEN_W'($urandom);
      if (!held) in_valid = (idx < n) && ($urandom_range(0, 99) >= stall_pct);
      in_data   = (idx < n) ? pl[idx] : 8'($urandom);
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (cyc == 1) check_eq({tag, "_busy_after_start"}, busy, 1);
      if (prev_stall) begin
        check_eq({tag, "_stall_valid"}, out_valid, 1);
        check_eq({tag, "_stall_data"}, out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        lasts.push_back(out_last);
        last_x = cyc;
      end
      held = in_valid && !in_ready;
      if (in_valid && in_ready) idx++;
      if (done) begin
        done_seen = 1;
        check_eq({tag, "_done_latency"}, cyc, last_x + 1);
        check_eq({tag, "_crc_value"}, crc_value, exp_crc);
        if (stall_pct == 0) check_eq({tag, "_frame_cycles"}, cyc, n + 2);
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq({tag, "_done_seen"}, done_seen, 1);
    check_eq({tag, "_out_count"}, got.size(), n + 1);
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
      check_eq($sformatf("%s_last%0d", tag, i), lasts[i], (i == n) ? 1 : 0);
    end
    @(posedge clk);
    @(negedge clk); #1;
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  // Check frame: msg is payload followed by the received CRC byte.
  task automatic run_chk(input byte_q_t msg, input int stall_pct, input bit poke, input string tag);
    int  idx = 0, last_x = -10;
    bit  held = 0, done_seen = 0, bad_ov = 0;
    int  n = msg.size() - 1;
    logic [7:0] exp_crc = ref_crc(msg);
    start_frame(1'b1, n);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      mode  = 1'($urandom);
      len   = LEN_W'($urandom);
      if (!held) in_valid = (idx <= n) && ($urandom_range(0, 99) >= stall_pct);
      in_data   = (idx <= n) ? msg[idx] : 8'($urandom);
      out_ready = 1'($urandom);
      #1;
      if (out_valid) bad_ov = 1;
      held = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        idx++;
        last_x = cyc;
      end
      if (done) begin
        done_seen = 1;
        check_eq({tag, "_done_latency"}, cyc, last_x + 1);
        check_eq({tag, "_consumed"}, idx, n + 1);
        check_eq({tag, "_crc_ok"}, crc_ok, (exp_crc == 8'h00) ? 1 : 0);
        check_eq({tag, "_crc_value"}, crc_value, exp_crc);
        if (stall_pct == 0) check_eq({tag, "_frame_cycles"}, cyc, n + 2);
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check_eq({tag, "_done_seen"}, done_seen, 1);
    check_eq({tag, "_no_out_valid"}, bad_ov, 0);
    @(posedge clk);
  endtask

  task automatic run_abort();
    byte_q_t pl;
    bit      done_any = 0;
    for (int i = 1; i <= 9; i++) pl.push_back(8'(8'h30 + i));
    start_frame(1'b0, 9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = pl[k]; out_ready = 1'b1;
      #1;
      check_eq($sformatf("abort_pre_xfer%0d", k), in_ready && out_valid, 1);
      @(posedge clk);
    end
    @(negedge clk);
    abort = 1'b1; in_data = pl[3];
    #1;
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_crc_ok", crc_ok, 0);
    done_any = done;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      done_any = done_any | done;
    end
    check_eq("abort_no_done", done_any, 0);
  endtask

  task automatic run_reset_mid_emit();
    start_frame(1'b0, 1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_emit_last", out_last, 1);
    check_eq("rst_emit_data", out_data, 8'h07);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_emit");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    byte_q_t q, s;
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("post_reset");

    q = {8'h01};
    run_gen(q, 0, 0, "gen1");
    check_eq("gen1_final_crc", crc_value, 8'h07);

    for (int i = 1; i <= 9; i++) s.push_back(8'(8'h30 + i));
    run_gen(s, 40, 0, "gen_check_string");
    check_eq("gen_check_string_crc", crc_value, 8'hF4);

    q = {8'hFF, 8'hF3};
    run_chk(q, 0, 0, "chk_good");
    check_eq("chk_good_ok", crc_ok, 1);
    q = {8'hFF, 8'hF2};
    run_chk(q, 0, 0, "chk_bad");
    check_eq("chk_bad_ok", crc_ok, 0);

    q = {};
    run_gen(q, 0, 0, "gen_len0");
    q = {8'h00};
    run_chk(q, 0, 0, "chk_len0");
    check_eq("chk_len0_ok", crc_ok, 1);

    // crc_ok is 1 going into the abort, so the abort must clear it.
    q = {8'hFF, 8'hF3};
    run_chk(q, 0, 0, "chk_before_abort");
    run_abort();
    q = {8'h01};
    run_gen(q, 0, 0, "gen_after_abort");

    run_gen(s, 30, 1, "gen_start_poke");
    q = s; q.push_back(8'hF4);
    run_chk(q, 30, 1, "chk_start_poke");

    run_reset_mid_emit();
    q = {8'h01};
    run_gen(q, 0, 0, "gen_after_reset");

    for (int f = 0; f < 40; f++) begin
      byte_q_t    pl;
      int         n = $urandom_range(0, 12);
      logic [7:0] c;
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        run_gen(pl, $urandom_range(0, 50), 1'($urandom), $sformatf("rnd%0d_gen", f));
      end else begin
        c = ref_crc(pl);
        if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
        pl.push_back(c);
        run_chk(pl, $urandom_range(0, 50), 1'($urandom), $sformatf("rnd%0d_chk", f));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Frame sequencer for the byte-wide CRC-8 datapath. It accepts a length-prefixed frame over a valid/ready byte stream and steps the CRC engine once per accepted byte. In generate mode it forwards the payload and appends the CRC byte. In check mode it consumes payload plus received CRC and reports pass/fail. It sits between the framing logic and the link, and is the only sequencer driving the CRC engine.

## Interface
- LEN_W, 8, width of the payload-length field (max payload 2^LEN_W−1 bytes)
- POLY, 8'h07, CRC-8 polynomial x^8+x^2+x+1, MSB-first, no reflection
- INIT, 8'h00, CRC register value loaded at frame start; no final XOR
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  frame start strobe, sampled only in IDLE
- mode  input  1  0 = generate, 1 = check; captured with start
- len  input  LEN_W  payload byte count; captured with start
- abort  input  1  synchronous frame abort, any state
- in_valid / in_ready  input / output  1 / 1  input byte handshake
- in_data  input  8  input byte
- out_valid / out_ready  output / input  1 / 1  output byte handshake
- out_data  output  8  output byte
- out_last  output  1  marks the appended CRC byte
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at frame completion
- crc_ok  output  1  check result, valid from done until next start
- crc_value  output  8  running/final CRC register

## Operation
- States: IDLE, DATA, EMIT (generate), CHKB (check), DONE.
- IDLE: in_ready=0, out_valid=0. start=1 → latch mode/len, crc←INIT, cnt←len. Next state is DATA if len≠0, else EMIT (gen) or CHKB (check).
- DATA, gen: pure pass-through. out_valid=in_valid, in_ready=out_ready, out_data=in_data, out_last=0.
- DATA, check: in_ready=1, out_valid=0.
- Transfer = in_valid & in_ready. Each transfer: crc←step(crc,in_data), cnt−1. The transfer with cnt==1 moves to EMIT (gen) or CHKB (check).
- EMIT: out_valid=1, out_data=crc, out_last=1, in_ready=0. Hold until out_ready, then DONE.
- CHKB: in_ready=1. On transfer, crc←step(crc,in_data). crc_ok←(step result==8'h00). Then DONE.
- DONE: done=1 for one cycle, then IDLE. crc_value holds the final value.
- start is ignored while busy.
- abort=1 in any non-IDLE state → IDLE next cycle, no done, crc_ok←0, no byte transferred that cycle (in_ready, out_valid forced 0).
- abort in IDLE is ignored. abort has priority over start in the same cycle.
- out_data/out_valid stay stable while out_valid & !out_ready (EMIT is registered; DATA mirrors the upstream source, which must itself hold).

## Timing
- Reset values: state=IDLE, crc_value=INIT, crc_ok=0, done=0, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
- start → busy high the next cycle; first byte can transfer in that cycle.
- Gen latency: the CRC byte is presented the cycle after the last payload transfer. done follows the cycle after the EMIT transfer.
- Check: done is asserted the cycle after the CRC-byte transfer, with crc_ok already valid.
- Throughput: one byte per cycle with no bubbles inside DATA. A frame costs len+2 cycles minimum (gen) or len+2 (check), plus one DONE cycle.
- Back-to-back: start may be asserted in the cycle after DONE, when the block is back in IDLE.

## Structure
- Shared package crc_pkg holds the POLY/INIT defaults, the state enum (IDLE, DATA, EMIT, CHKB, DONE) and the CRC width constant (8).
- Sub-module crc8_step: combinational (crc[7:0], data[7:0]) → next[7:0], eight unrolled MSB-first shift/XOR stages on POLY. This is the datapath the controller sequences. The controller holds the crc register, byte counter and FSM.

## Test plan
- Gen, len=1, byte 0x01 → out: 0x01, then 0x07 with out_last=1; done pulse one cycle later.
- Gen, len=9, ASCII "123456789" with random out_ready stalls → payload forwarded unchanged, CRC byte 0xF4, stable data under every stall.
- Check, len=1, bytes 0xFF, 0xF3 → done with crc_ok=1. Repeat with 0xFF, 0xF2 → crc_ok=0.
- len=0: gen emits a single 0x00 with out_last. Check with CRC byte 0x00 gives crc_ok=1.
- abort after 3 of 9 bytes: busy drops next cycle, no done, crc_ok=0. A following gen frame of 0x01 still yields 0x07.
- rst_n low mid-EMIT → all outputs at reset values immediately. start asserted while busy is ignored, and the frame result is unchanged.
